uart_paddle_frame_ctrl: RTL and testbench
=========================================

// Module: uart_paddle_frame_ctrl
// PURPOSE
//  Frame controller sitting after the UART receiver in the motion-control pong link.
//  Consumes received bytes (one-cycle valid strobe), hunts for sync, parses 4-byte
//  paddle frames {SYNC, ID, POS, CSUM}, validates them and publishes per-player paddle
//  positions to the game logic. Adds inter-byte timeout, link-alive status, error count.
// PARAMETERS
//  SYNC_BYTE     8'hA5        frame start marker
//  CSUM_SEED     8'h5A        checksum seed: CSUM = ID ^ POS ^ CSUM_SEED
//  MAX_POS       8'd200       paddle positions above this are clamped to MAX_POS
//  BYTE_TIMEOUT  208_333      max clk_fpga cycles between bytes inside a frame (~2 bytes @9600)
//  LINK_TIMEOUT  10_000_000   cycles without a good frame before link_up drops (100 ms)
// PORTS
//  clk_fpga   in   1  100 MHz board clock
//  reset_n    in   1  asynchronous, active-low reset
//  rx_byte    in   8  received data byte, valid only when rx_valid=1
//  rx_valid   in   1  one-cycle strobe, one per received byte
//  p1_pos     out  8  last accepted player-1 paddle position
//  p2_pos     out  8  last accepted player-2 paddle position
//  p1_upd     out  1  one-cycle pulse when p1_pos is updated
//  p2_upd     out  1  one-cycle pulse when p2_pos is updated
//  frame_err  out  1  one-cycle pulse on bad ID, bad checksum or inter-byte timeout
//  err_count  out  8  count of frame_err pulses, saturates at 8'hFF
//  link_up    out  1  1 while a good frame was accepted within LINK_TIMEOUT cycles
// BEHAVIOUR
//  Reset (reset_n=0, async): state=HUNT, p1_pos=p2_pos=MAX_POS/2 (8'd100), all pulses 0,
//   err_count=0, link_up=0, both timeout counters 0. Reset mid-frame discards the frame.
//  FSM advances only on cycles with rx_valid=1 (except timeout):
//   HUNT : byte==SYNC_BYTE -> GET_ID; any other byte ignored, no error.
//   GET_ID: ID 8'h01 or 8'h02 -> latch ID, GET_POS; other -> frame_err, HUNT.
//   GET_POS: latch POS (any value, incl. SYNC_BYTE) -> GET_CSUM.
//   GET_CSUM: byte==ID^POS^CSUM_SEED -> accept, HUNT; else frame_err, HUNT.
//  Accept: registered outputs; cycle after CSUM strobe p<ID>_pos=min(POS,MAX_POS),
//   p<ID>_upd=1 for exactly one cycle, link timer cleared, link_up=1. Other player untouched.
//  Inter-byte timer: counts in GET_ID/GET_POS/GET_CSUM, cleared on every rx_valid and in HUNT.
//   Reaching BYTE_TIMEOUT -> frame_err pulse, HUNT. If rx_valid arrives in the same cycle
//   the timer would expire, the byte wins (processed normally, no timeout).
//  Link timer: free-runs, cleared on accept; at LINK_TIMEOUT sets link_up=0 and holds
//   (saturates, no wrap). Positions keep last values when link drops.
//  frame_err and accept never coincide; err_count increments same cycle frame_err is 1,
//   stays at 255 once reached.
//  Widths: timers sized by $clog2(param+1); comparisons unsigned, clamp is unsigned compare.
// STRUCTURE
//  pong_uart_pkg: SYNC_BYTE, CSUM_SEED, player ID constants (ID_P1, ID_P2), FSM state
//   encoding (HUNT, GET_ID, GET_POS, GET_CSUM), MAX_POS; shared with future tx framer.
//  Sub-module uart_timeout_ctr (param LIMIT; inputs clear, enable; output expired),
//   instantiated twice: inter-byte timer and link timer. Everything else in this module.
// TESTING
//  1 Good frame A5 01 64 3F -> cycle after CSUM: p1_pos=8'h64, p1_upd 1-cycle, link_up=1,
//    p2_pos=100, frame_err never 1.
//  2 Noise 00 FF 13 then A5 02 32 6A -> noise ignored (err_count 0), p2_pos=8'h32, p2_upd pulse.
//  3 Bad CSUM A5 02 10 00 -> frame_err pulse after CSUM, err_count=1, p2_pos unchanged.
//  4 Bad ID A5 07 then A5 01 FF A4 -> frame_err on ID byte, then p1_pos clamped to 8'hC8.
//  5 A5 01 then silence BYTE_TIMEOUT cycles -> one frame_err, HUNT; new good frame accepted;
//    silence LINK_TIMEOUT after it -> link_up=0, positions held.
//  6 reset_n low during GET_POS -> outputs immediately at reset values; following CSUM byte
//    alone produces no update; 256+ errors -> err_count holds 8'hFF.

Source files
------------

// File: rtl/pong_uart_pkg.sv
// Shared definitions for the pong UART link (frame controller today, tx framer later).
//   SYNC_BYTE / CSUM_SEED : frame marker and checksum seed
//   ID_P1 / ID_P2         : player identifiers carried in the ID byte
//   MAX_POS               : paddle position ceiling; larger positions are clamped
//   state_t               : frame parser states
//   frame_t               : ID/POS latched while a frame is being parsed
package pong_uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CSUM_SEED = 8'h5A;
  localparam logic [7:0] ID_P1     = 8'h01;
  localparam logic [7:0] ID_P2     = 8'h02;
  localparam logic [7:0] MAX_POS   = 8'd200;
  localparam logic [7:0] POS_RST   = 8'd100;  // centre of the field (MAX_POS/2)

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    GET_ID   = 2'd1,
    GET_POS  = 2'd2,
    GET_CSUM = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] pos;
  } frame_t;

  function automatic logic [7:0] calc_csum(input logic [7:0] id, input logic [7:0] pos);
    return id ^ pos ^ CSUM_SEED;
  endfunction

  function automatic logic [7:0] clamp_pos(input logic [7:0] pos);
    return (pos > MAX_POS) ? MAX_POS : pos;
  endfunction

endpackage

// File: rtl/uart_paddle_frame_ctrl_if.sv
// Byte stream in from the UART receiver and paddle status out to the game logic.
//   master : producer of rx_byte/rx_valid, consumer of paddle/link status
//   slave  : the frame controller
interface uart_paddle_frame_ctrl_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] p1_pos;
  logic [7:0] p2_pos;
  logic       p1_upd;
  logic       p2_upd;
  logic       frame_err;
  logic [7:0] err_count;
  logic       link_up;

  modport master (
    output rx_byte, rx_valid,
    input  p1_pos, p2_pos, p1_upd, p2_upd, frame_err, err_count, link_up
  );

  modport slave (
    input  rx_byte, rx_valid,
    output p1_pos, p2_pos, p1_upd, p2_upd, frame_err, err_count, link_up
  );
endinterface

// File: rtl/uart_timeout_ctr.sv
// Saturating cycle counter used for timeouts.
//   clk_fpga, reset_n : clock, async active-low reset
//   clear             : synchronous clear (wins over enable)
//   enable            : count one cycle
//   expired           : high while the count equals LIMIT; the count holds there
module uart_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_fpga,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LIM);

endmodule

// File: rtl/uart_paddle_frame_ctrl.sv
// Frame controller behind the UART receiver: hunts for SYNC, parses
// {SYNC, ID, POS, CSUM} frames, publishes clamped per-player paddle positions.
//   clk_fpga, reset_n : 100 MHz clock, async active-low reset
//   bus (slave)       : rx_byte/rx_valid in; p1/p2_pos, p1/p2_upd, frame_err,
//                       err_count, link_up out (all outputs registered)
//   BYTE_TIMEOUT      : max idle cycles between bytes inside a frame
//   LINK_TIMEOUT      : cycles without a good frame before link_up drops
module uart_paddle_frame_ctrl
  import pong_uart_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 208_333,
  parameter int unsigned LINK_TIMEOUT = 10_000_000
) (
  input  logic                     clk_fpga,
  input  logic                     reset_n,
  uart_paddle_frame_ctrl_if.slave  bus
);

  state_t state_q, state_d;
  frame_t frm_q, frm_d;
  logic   accept_c, err_c;
  logic   byte_exp, link_exp;

  // Inter-byte timer only runs mid-frame; any byte or a return to HUNT restarts it.
  uart_timeout_ctr #(.LIMIT(BYTE_TIMEOUT)) u_byte_tmr (
    .clk_fpga (clk_fpga),
    .reset_n  (reset_n),
    .clear    (bus.rx_valid || (state_q == HUNT) || err_c),
    .enable   (state_q != HUNT),
    .expired  (byte_exp)
  );

  // Link timer free-runs and saturates; only a good frame restarts it.
  uart_timeout_ctr #(.LIMIT(LINK_TIMEOUT)) u_link_tmr (
    .clk_fpga (clk_fpga),
    .reset_n  (reset_n),
    .clear    (accept_c),
    .enable   (1'b1),
    .expired  (link_exp)
  );

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;
      frm_q   <= frm_d;
    end
  end

  // A byte on the same cycle as expiry takes priority: rx_valid is checked first.
  always_comb begin
    state_d  = state_q;
    frm_d    = frm_q;
    accept_c = 1'b0;
    err_c    = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) state_d = GET_ID;
      end
      GET_ID: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte == ID_P1 || bus.rx_byte == ID_P2) begin
            frm_d.id = bus.rx_byte;
            state_d  = GET_POS;
          end else begin
            err_c   = 1'b1;
            state_d = HUNT;
          end
        end else if (byte_exp) begin
          err_c   = 1'b1;
          state_d = HUNT;
        end
      end
      GET_POS: begin
        if (bus.rx_valid) begin
          frm_d.pos = bus.rx_byte;
          state_d   = GET_CSUM;
        end else if (byte_exp) begin
          err_c   = 1'b1;
          state_d = HUNT;
        end
      end
      GET_CSUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte == calc_csum(frm_q.id, frm_q.pos)) accept_c = 1'b1;
          else                                                err_c    = 1'b1;
          state_d = HUNT;
        end else if (byte_exp) begin
          err_c   = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      bus.p1_pos    <= POS_RST;
      bus.p2_pos    <= POS_RST;
      bus.p1_upd    <= 1'b0;
      bus.p2_upd    <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_count <= '0;
      bus.link_up   <= 1'b0;
    end else begin
      bus.p1_upd    <= accept_c && (frm_q.id == ID_P1);
      bus.p2_upd    <= accept_c && (frm_q.id == ID_P2);
      bus.frame_err <= err_c;
      if (accept_c && frm_q.id == ID_P1) bus.p1_pos <= clamp_pos(frm_q.pos);
      if (accept_c && frm_q.id == ID_P2) bus.p2_pos <= clamp_pos(frm_q.pos);
      if (err_c && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
      if (accept_c)      bus.link_up <= 1'b1;
      else if (link_exp) bus.link_up <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_paddle_frame_ctrl.sv
module tb_uart_paddle_frame_ctrl;
  localparam int unsigned BT = 50;
  localparam int unsigned LT = 400;
  localparam int K_P1 = 0, K_P2 = 1, K_ERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] pos;
  } exp_t;

  logic clk_fpga = 1'b0;
  logic reset_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  uart_paddle_frame_ctrl_if bus();

  uart_paddle_frame_ctrl #(.BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut (
    .clk_fpga (clk_fpga),
    .reset_n  (reset_n),
    .bus      (bus.slave)
  );

  always #5 clk_fpga = ~clk_fpga;

  // Scoreboard: every output pulse must match the next queued expectation.
  always @(negedge clk_fpga) begin
    if (reset_n) begin
      logic [2:0] pulses;
      logic [7:0] got;
      exp_t e;
      pulses = {bus.frame_err, bus.p2_upd, bus.p1_upd};
      if (bus.frame_err && (bus.p1_upd || bus.p2_upd)) begin
        checks++; errors++;
        $display("FAIL err_and_upd got err=1 upd=%b%b need exclusive", bus.p2_upd, bus.p1_upd);
      end
      for (int k = 0; k < 3; k++) begin
        if (pulses[k]) begin
          got = (k == K_P1) ? bus.p1_pos : (k == K_P2) ? bus.p2_pos : 8'h00;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got kind=%0d pos=%h need no pulse", k, got);
          end else begin
            e = sb.pop_front();
            if (e.kind !== k || e.pos !== got) begin
              errors++;
              $display("FAIL sb_pulse got kind=%0d pos=%h need kind=%0d pos=%h", k, got, e.kind, e.pos);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input int kind, input logic [7:0] pos);
    exp_t e;
    e.kind = kind; e.pos = pos;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_fpga); #1;
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk_fpga); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk_fpga);
    repeat (2) @(posedge clk_fpga);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending need 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.rx_byte = 8'h00; bus.rx_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_fpga);
    #1;
    checks++;
    if (bus.p1_pos !== 8'd100 || bus.p2_pos !== 8'd100 || bus.p1_upd !== 1'b0 ||
        bus.p2_upd !== 1'b0 || bus.frame_err !== 1'b0 || bus.err_count !== 8'd0 ||
        bus.link_up !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals got p1=%h p2=%h upd=%b%b err=%b cnt=%h link=%b need 64 64 00 0 00 0",
               bus.p1_pos, bus.p2_pos, bus.p1_upd, bus.p2_upd, bus.frame_err, bus.err_count, bus.link_up);
    end
    @(negedge clk_fpga) reset_n = 1'b1;
  endtask

  task automatic test_good_frame();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h64);
    push_exp(K_P1, 8'h64);
    send_byte(8'h3F);
    drain("good");
    checks++;
    if (bus.link_up !== 1'b1 || bus.p2_pos !== 8'd100 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL good_status got link=%b p2=%h cnt=%h need 1 64 00", bus.link_up, bus.p2_pos, bus.err_count);
    end
  endtask

  task automatic test_noise();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h32);
    push_exp(K_P2, 8'h32);
    send_byte(8'h6A);
    drain("noise");
    checks++;
    if (bus.err_count !== 8'd0 || bus.p1_pos !== 8'h64) begin
      errors++;
      $display("FAIL noise_status got cnt=%h p1=%h need 00 64", bus.err_count, bus.p1_pos);
    end
  endtask

  task automatic test_bad_csum();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    push_exp(K_ERR, 8'h00);
    send_byte(8'h00);
    drain("badcsum");
    checks++;
    if (bus.err_count !== 8'd1 || bus.p2_pos !== 8'h32) begin
      errors++;
      $display("FAIL badcsum_status got cnt=%h p2=%h need 01 32", bus.err_count, bus.p2_pos);
    end
  endtask

  task automatic test_bad_id();
    send_byte(8'hA5);
    push_exp(K_ERR, 8'h00);
    send_byte(8'h07);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hFF);
    push_exp(K_P1, 8'hC8);
    send_byte(8'hA4);
    drain("badid");
    checks++;
    if (bus.err_count !== 8'd2) begin
      errors++;
      $display("FAIL badid_cnt got %h need 02", bus.err_count);
    end
  endtask

  task automatic test_timeout();
    // Byte arriving exactly on the expiry cycle is processed, no error.
    send_byte(8'hA5);
    repeat (BT - 1) @(posedge clk_fpga);
    send_byte(8'h01); send_byte(8'h33);
    push_exp(K_P1, 8'h33);
    send_byte(8'h01 ^ 8'h33 ^ 8'h5A);
    drain("tmo_edge");
    // One cycle later the timer wins; the late ID byte falls into HUNT.
    send_byte(8'hA5);
    push_exp(K_ERR, 8'h00);
    repeat (BT) @(posedge clk_fpga);
    send_byte(8'h01);
    drain("tmo_late");
    // Long silence mid-frame gives exactly one error.
    send_byte(8'hA5); send_byte(8'h01);
    push_exp(K_ERR, 8'h00);
    repeat (BT + 20) @(posedge clk_fpga);
    drain("tmo_idle");
    checks++;
    if (bus.err_count !== 8'd4) begin
      errors++;
      $display("FAIL tmo_cnt got %h need 04", bus.err_count);
    end
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h55);
    push_exp(K_P2, 8'h55);
    send_byte(8'h0D);
    drain("tmo_recover");
  endtask

  task automatic test_link();
    repeat (LT - 40) @(posedge clk_fpga);
    #1;
    checks++;
    if (bus.link_up !== 1'b1) begin
      errors++;
      $display("FAIL link_alive got %b need 1", bus.link_up);
    end
    repeat (60) @(posedge clk_fpga);
    #1;
    checks++;
    if (bus.link_up !== 1'b0 || bus.p1_pos !== 8'h33 || bus.p2_pos !== 8'h55) begin
      errors++;
      $display("FAIL link_drop got link=%b p1=%h p2=%h need 0 33 55", bus.link_up, bus.p1_pos, bus.p2_pos);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5); send_byte(8'h01);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.p1_pos !== 8'd100 || bus.p2_pos !== 8'd100 || bus.err_count !== 8'd0 || bus.link_up !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got p1=%h p2=%h cnt=%h link=%b need 64 64 00 0",
               bus.p1_pos, bus.p2_pos, bus.err_count, bus.link_up);
    end
    repeat (2) @(posedge clk_fpga);
    @(negedge clk_fpga) reset_n = 1'b1;
    send_byte(8'h40); send_byte(8'h1B);
    drain("rst_orphan");
    checks++;
    if (bus.p1_pos !== 8'd100 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_orphan_state got p1=%h cnt=%h need 64 00", bus.p1_pos, bus.err_count);
    end
  endtask

  task automatic test_err_sat();
    for (int i = 0; i < 255; i++) begin
      send_byte(8'hA5);
      push_exp(K_ERR, 8'h00);
      send_byte(8'h07);
    end
    drain("sat_fill");
    checks++;
    if (bus.err_count !== 8'hFF) begin
      errors++;
      $display("FAIL sat_255 got %h need FF", bus.err_count);
    end
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hA5);
      push_exp(K_ERR, 8'h00);
      send_byte(8'h09);
    end
    drain("sat_hold");
    checks++;
    if (bus.err_count !== 8'hFF) begin
      errors++;
      $display("FAIL sat_hold got %h need FF", bus.err_count);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_noise();
    test_bad_csum();
    test_bad_id();
    test_timeout();
    test_link();
    test_reset_mid();
    test_err_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
